// File: rtl/matrix_cfg_pkg.sv
// ============================================================================
// Module   : matrix_cfg_pkg
// Brief    : Shared constants, FSM state codes and side codes for the
//            5x4 switch-matrix configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_cfg_pkg;

  localparam int NTOP  = 5;
  localparam int NSIDE = 4;
  localparam int WW    = 6;
  localparam int NW    = 2*NTOP + 2*NSIDE;
  localparam int CW    = $clog2(NW + 1);
  localparam logic [7:0] HDR = 8'hA5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_CHK  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef enum logic [2:0] {
    SIDE_NONE = 3'd0,
    TOP       = 3'd1,
    RIGHT     = 3'd2,
    BOTTOM    = 3'd3,
    LEFT      = 3'd4
  } side_e;

  // Number of wires reachable on a given side; 0 means no index limit applies.
  function automatic logic [2:0] side_limit(input logic [2:0] side);
    case (side)
      TOP, BOTTOM: side_limit = 3'(NTOP);
      RIGHT, LEFT: side_limit = 3'(NSIDE);
      default:     side_limit = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_cfg_word_check.sv
// ============================================================================
// Module   : matrix_cfg_word_check
// Brief    : Combinational validity check of one routing byte for a slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_cfg_word_check
  import matrix_cfg_pkg::*;
(
  input  logic [7:0]    data,
  input  logic [CW-1:0] slot,
  output logic          invalid
);

  logic [2:0] w_side;
  logic [2:0] w_idx;

  always_comb begin
    w_side  = data[2:0];
    w_idx   = data[5:3];
    // A slot outside the frame can never hold a legal word.
    invalid = (data[7:6] != 2'b00) || (slot >= CW'(NW));
    case (w_side)
      SIDE_NONE:                   ;
      TOP, BOTTOM, RIGHT, LEFT: if (w_idx >= side_limit(w_side)) invalid = 1'b1;
      default:                     invalid = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/matrix_cfg_loader.sv
// ============================================================================
// Module   : matrix_cfg_loader
// Brief    : Framed byte-stream loader; validates 18 routing words into a
//            shadow bank and commits them atomically to the active bank.
//            Define MATRIX_CFG_CHECKSUM_EN to require a trailing XOR byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_cfg_loader
  import matrix_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_data,
  output logic              cfg_ready,
  input  logic              cfg_abort,
  output logic [NW*WW-1:0]  cfg_words,
  output logic              cfg_commit,
  output logic              cfg_err,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic              r_bad;
  logic [NW*WW-1:0]  r_shadow;
  logic [NW*WW-1:0]  r_active;
  logic              w_xfer;
  logic              w_hdr;
  logic              w_last;
  logic              w_load_we;
  logic              w_invalid;

`ifdef MATRIX_CFG_CHECKSUM_EN
  logic [7:0]        r_xor;
  localparam state_t c_after_load = ST_CHK;
`else
  localparam state_t c_after_load = ST_DONE;
`endif

  assign cfg_ready  = (r_state != ST_DONE);
  assign w_xfer     = cfg_valid & cfg_ready;
  assign w_hdr      = (cfg_data == HDR);
  assign w_last     = (r_cnt == CW'(NW - 1));
  assign w_load_we  = (r_state == ST_LOAD) & w_xfer & ~cfg_abort;
  assign busy       = (r_state != ST_IDLE);
  // An abort during DONE cancels the pending commit/error outcome.
  assign cfg_commit = (r_state == ST_DONE) & ~r_bad & ~cfg_abort;
  assign cfg_err    = (r_state == ST_DONE) &  r_bad & ~cfg_abort;
  assign cfg_words  = r_active;

  matrix_cfg_word_check u_word_check (
    .data    (cfg_data),
    .slot    (r_cnt),
    .invalid (w_invalid)
  );

  always_comb begin
    w_state_nx = r_state;
    if (cfg_abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_xfer && w_hdr)  w_state_nx = ST_LOAD;
        ST_LOAD: if (w_xfer && w_last) w_state_nx = c_after_load;
`ifdef MATRIX_CFG_CHECKSUM_EN
        ST_CHK:  if (w_xfer)           w_state_nx = ST_DONE;
`endif
        default:                       w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bad    <= 1'b0;
      r_shadow <= '0;
      r_active <= '0;
`ifdef MATRIX_CFG_CHECKSUM_EN
      r_xor    <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      for (int k = 0; k < NW; k++) begin
        if (w_load_we && (r_cnt == CW'(k))) r_shadow[k*WW +: WW] <= cfg_data[WW-1:0];
      end
      if (cfg_abort) begin
        r_cnt <= '0;
        r_bad <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_xfer && w_hdr) begin
              r_cnt <= '0;
              r_bad <= 1'b0;
`ifdef MATRIX_CFG_CHECKSUM_EN
              r_xor <= '0;
`endif
            end
          end
          ST_LOAD: begin
            if (w_xfer) begin
              r_cnt <= r_cnt + 1'b1;
              r_bad <= r_bad | w_invalid;
`ifdef MATRIX_CFG_CHECKSUM_EN
              r_xor <= r_xor ^ cfg_data;
`endif
            end
          end
`ifdef MATRIX_CFG_CHECKSUM_EN
          ST_CHK: begin
            if (w_xfer) r_bad <= r_bad | (cfg_data != r_xor);
          end
`endif
          ST_DONE: begin
            if (!r_bad) r_active <= r_shadow;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
